mul_seq: RTL and testbench

Sequential shift-add multiply-accumulate unit, the inverse counterpart to the team's restoring divider. It computes prod = mcand × mplier + addend over 2·WIDTH bits, one multiplier bit per clock. A divider result can be fed straight back in (quotient, divisor, remainder) to rebuild the dividend. It sits beside the divider in the arithmetic datapath and uses a start/busy/done handshake.

---
 rtl/mul_seq_if.sv | 23 ++
 rtl/mul_seq.sv | 98 +++++++++
 tb/tb_mul_seq.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_if.sv
// mul_seq_if: start/busy/done handshake and operand/result bus of mul_seq.
// master issues operands and start; slave (the multiplier) returns prod/busy/done.
interface mul_seq_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] prod;
    logic               busy;
    logic               done;

    modport master (
        output start, mcand, mplier, addend,
        input  prod, busy, done
    );

    modport slave (
        input  start, mcand, mplier, addend,
        output prod, busy, done
    );
endinterface

// File: rtl/mul_seq.sv
// mul_seq: shift-add multiply-accumulate, prod = mcand * mplier + addend mod 2^(2W).
// Define MUL_SEQ_EARLY_EXIT_EN to finish once no set multiplier bits remain.
module mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    mul_seq_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e state_q, state_d;

    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    msh_q, msh_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [WIDTH-1:0] mr_q, mr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             done_q, done_d;

    logic [PW-1:0]    sum;
    logic             last;
    logic             finish;

    assign last = (count_q == CW'(WIDTH - 1));

`ifdef MUL_SEQ_EARLY_EXIT_EN
    // Remaining multiplier bits are all zero: later iterations add nothing.
    assign finish = last || ((mr_q >> 1) == '0);
`else
    assign finish = last;
`endif

    assign sum = mr_q[0] ? (acc_q + msh_q) : acc_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        msh_d   = msh_q;
        mr_d    = mr_q;
        count_d = count_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = bus.addend;
                    msh_d   = {{WIDTH{1'b0}}, bus.mcand};
                    mr_d    = bus.mplier;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = sum;
                msh_d   = msh_q << 1;
                mr_d    = mr_q >> 1;
                count_d = count_q + CW'(1);
                if (finish) begin
                    prod_d  = sum;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            msh_q   <= '0;
            mr_q    <= '0;
            count_q <= '0;
            prod_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            msh_q   <= msh_d;
            mr_q    <= mr_d;
            count_q <= count_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end

    assign bus.prod = prod_q;
    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed vectors for mul_seq, checked against a per-cycle
// transaction model plus literal expectations for each vector.
module tb_mul_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;

    mul_seq_if #(.WIDTH(32)) bus ();

    mul_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

`ifdef MUL_SEQ_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_left = 0;
    logic [63:0] m_res = '0;
    logic [63:0] m_prod = '0;

    function automatic int lat_of(input logic [31:0] mp);
        int n;
        n = 32;
        if (EE) begin
            n = 1;
            for (int i = 0; i < 32; i++)
                if (mp[i]) n = i + 1;
        end
        return n;
    endfunction

    // Transaction model: result is plain arithmetic, latency a countdown.
    always @(posedge clk) begin
        cyc++;
        m_done = 1'b0;
        if (reset) begin
            m_busy = 1'b0;
            m_left = 0;
            m_prod = '0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_prod = m_res;
            end
        end else if (bus.start) begin
            m_busy = 1'b1;
            m_left = lat_of(bus.mplier);
            m_res  = {32'b0, bus.mcand} * {32'b0, bus.mplier} + bus.addend;
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model busy", {63'b0, bus.busy}, {63'b0, m_busy});
            chk("model done", {63'b0, bus.done}, {63'b0, m_done});
            chk("model prod", bus.prod, m_prod);
        end
    end

    task automatic launch(input logic [31:0] mc, input logic [31:0] mp,
                          input logic [63:0] ad, output int t0);
        @(negedge clk);
        bus.mcand  = mc;
        bus.mplier = mp;
        bus.addend = ad;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int t0, input string name, output int lat);
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            if (bus.done) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: no done within 100 cycles", name);
        end
    endtask

    task automatic op(input string name, input logic [31:0] mc,
                      input logic [31:0] mp, input logic [63:0] ad,
                      input logic [63:0] exp_p, input int exp_lat);
        int t0;
        int lat;
        launch(mc, mp, ad, t0);
        wait_done(t0, name, lat);
        chk({name, " latency"}, 64'(lat), 64'(exp_lat));
        chk({name, " prod"}, bus.prod, exp_p);
    endtask

    task automatic count_dones(input string name, input int ncyc);
        int nd;
        nd = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        chk(name, 64'(nd), 64'd0);
    endtask

    initial begin
        int t0;
        int t1;
        int lat;
        bus.start  = 1'b0;
        bus.mcand  = '0;
        bus.mplier = '0;
        bus.addend = '0;
        reset      = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        chk("reset busy", {63'b0, bus.busy}, 64'd0);
        chk("reset done", {63'b0, bus.done}, 64'd0);
        chk("reset prod", bus.prod, 64'd0);
        reset = 1'b0;

        op("7x6", 32'd7, 32'd6, 64'd0, 64'd42, EE ? 3 : 32);
        op("roundtrip", 32'h1234_5678, 32'h0000_ABCD, 64'h1234,
           64'h0000_0C37_89AB_784C, EE ? 16 : 32);
        op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1_FFFF_FFFE,
           64'hFFFF_FFFF_FFFF_FFFF, 32);
        op("wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1_FFFF_FFFF,
           64'h0, 32);
        op("mplier0", 32'hDEAD_BEEF, 32'd0, 64'h55, 64'h55, EE ? 1 : 32);
        op("mplier1", 32'd9, 32'd1, 64'd1, 64'd10, EE ? 1 : 32);

        // Start pulsed on cycle 5 of a busy run must be ignored.
        launch(32'd1000, 32'hF000_0000, 64'd5, t0);
        repeat (3) @(negedge clk);
        bus.mcand  = 32'd3;
        bus.mplier = 32'd3;
        bus.addend = 64'd0;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(t0, "ignore", lat);
        chk("ignore latency", 64'(lat), 64'd32);
        chk("ignore prod", bus.prod, 64'h0000_03A9_8000_0005);
        count_dones("ignore extra done", 40);

        // Back-to-back: next start held during the done cycle.
        launch(32'd7, 32'd6, 64'd0, t0);
        wait_done(t0, "b2b first", lat);
        chk("b2b first prod", bus.prod, 64'd42);
        t1 = cyc;
        bus.mcand  = 32'h10;
        bus.mplier = 32'h10;
        bus.addend = 64'd0;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            if (bus.done) begin
                lat = cyc - t1;
                break;
            end
            chk("b2b prod hold", bus.prod, 64'd42);
            @(negedge clk);
        end
        chk("b2b done gap", 64'(lat), 64'(EE ? 6 : 33));
        chk("b2b second prod", bus.prod, 64'h100);

        // Reset on cycle 10 of a run aborts it.
        launch(32'd7, 32'hFFFF_FFFF, 64'd1, t0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", {63'b0, bus.busy}, 64'd0);
        chk("abort done", {63'b0, bus.done}, 64'd0);
        chk("abort prod", bus.prod, 64'd0);
        count_dones("abort no done", 40);
        op("after abort", 32'd7, 32'd6, 64'd0, 64'd42, EE ? 3 : 32);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
